// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for a single-cycle CPU data port. Holds a word-addressed
// data RAM with combinational read, plus a small MMIO window: a free-running
// cycle counter, an accepted-RAM-write counter and a sticky done/result register
// that a program writes to announce completion and hand back its result.

module data_mem_responder #(
    parameter int unsigned ADDR_BITS   = 6,
    parameter logic [31:0] DONE_ADDR   = 32'hFFFF_FFF0,
    parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4,
    parameter logic [31:0] WCOUNT_ADDR = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    input  logic        write_enable,
    output logic [31:0] data_from_mem,
    output logic        done,
    output logic [31:0] result
);

    // RAM geometry: DEPTH words, byte addresses 0 .. RAM_LIMIT-1.
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH);
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    // Which target the current address selects.
    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_DONE   = 3'd1,
        SEL_CYCLE  = 3'd2,
        SEL_WCOUNT = 3'd3,
        SEL_NONE   = 3'd4
    } sel_e;

    // Full 32-bit decode; RAM wins over MMIO because the windows never overlap.
    function automatic sel_e decode_addr(input logic [31:0] addr);
        sel_e sel;
        if (addr < RAM_LIMIT) begin
            sel = SEL_RAM;
        end else if (addr == DONE_ADDR) begin
            sel = SEL_DONE;
        end else if (addr == CYCLE_ADDR) begin
            sel = SEL_CYCLE;
        end else if (addr == WCOUNT_ADDR) begin
            sel = SEL_WCOUNT;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] next_value;
        if (value == ALL_ONES) begin
            next_value = value;
        end else begin
            next_value = value + 32'd1;
        end
        return next_value;
    endfunction

    // Storage and state.
    logic [31:0]          r_mem [DEPTH];
    logic                 r_done;
    logic [31:0]          r_result;
    logic [31:0]          r_cycle_cnt;
    logic [31:0]          r_wcount;

    // Decode and write-qualification wires.
    sel_e                 w_sel;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_accept;
    logic                 w_ram_we;
    logic                 w_done_we;
    logic [31:0]          w_rdata;

    assign w_sel  = decode_addr(address_to_mem);
    assign w_idx  = address_to_mem[ADDR_BITS+1:2];

    // Once done is raised every write is dropped until the next reset.
    assign w_accept  = write_enable & ~r_done;
    assign w_ram_we  = w_accept & (w_sel == SEL_RAM);
    assign w_done_we = w_accept & (w_sel == SEL_DONE);

    // RAM write port; contents survive reset, but no write lands while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) begin
            r_mem[w_idx] <= data_to_mem;
        end
    end

    // Sticky completion flag and the result value that accompanied it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_result <= 32'h0;
        end else if (w_done_we) begin
            r_done   <= 1'b1;
            r_result <= data_to_mem;
        end else begin
            r_done   <= r_done;
            r_result <= r_result;
        end
    end

    // Free-running cycle counter; the edge that sets done still counts, then it freezes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= 32'h0;
        end else if (!r_done) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    // Counts accepted RAM writes only; MMIO and unmapped writes leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcount <= 32'h0;
        end else if (w_ram_we) begin
            r_wcount <= sat_inc(r_wcount);
        end else begin
            r_wcount <= r_wcount;
        end
    end

    // Zero-latency read mux; a same-cycle write to the word shows up only after the edge.
    always_comb begin
        w_rdata = 32'h0;
        case (w_sel)
            SEL_RAM:    w_rdata = r_mem[w_idx];
            SEL_DONE:   w_rdata = r_result;
            SEL_CYCLE:  w_rdata = r_cycle_cnt;
            SEL_WCOUNT: w_rdata = r_wcount;
            SEL_NONE:   w_rdata = 32'h0;
            default:    w_rdata = 32'h0;
        endcase
    end

    assign data_from_mem = w_rdata;
    assign done          = r_done;
    assign result        = r_result;

endmodule
